sgdma_desc_fetcher: RTL and testbench

//  Avalon-MM master that walks a linked chain of 32-byte DMA descriptors held in the
//  on-chip descriptor RAM slave (32-bit, 1-cycle read latency). Hands each owned

---
 rtl/sgdma_desc_fetcher.sv | 198 +++++++++++++++++++
 tb/tb_sgdma_desc_fetcher.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgdma_desc_fetcher.sv
// Walks a linked chain of 32-byte descriptors over Avalon-MM and offers each owned one to the datapath. Optional irq/irq_clear ports come with SGDMA_DESC_FETCHER_IRQ_EN.
// Latency: 8 single reads (>= 2 cycles each) plus 1 check cycle per offer; the completion write-back is issued on the cycle after xfer_done.
// Backpressure: bus requests are held while m_waitrequest=1; the offer is held until desc_ready or stop.
module sgdma_desc_fetcher #(
  parameter int ADDR_W   = 32,
  parameter int MAX_DESC = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] head_ptr,
  input  logic              stop,
  output logic              busy,
  output logic              chain_done,
  output logic              chain_err,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  input  logic              m_waitrequest,
  input  logic [31:0]       m_readdata,
  input  logic              m_readdatavalid,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [31:0]       desc_src,
  output logic [31:0]       desc_dst,
  output logic [15:0]       desc_len,
  input  logic              xfer_done,
  input  logic [15:0]       xfer_bytes,
`ifdef SGDMA_DESC_FETCHER_IRQ_EN
  output logic              irq,
  input  logic              irq_clear,
`endif
  input  logic [7:0]        xfer_status
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_OFFER = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_WB    = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [2:0]        rd_idx;
  logic              rd_wait;
  logic              stop_seen;
  logic [31:0]       w0, w2, w4;
  logic [15:0]       w6_len;
  logic [7:0]        w7_hi;
  logic [31:0]       cnt;
  logic [31:0]       cnt_nxt;
  logic              max_hit;

  assign m_byteenable = 4'hF;
  assign desc_src     = w0;
  assign desc_dst     = w2;
  assign desc_len     = w6_len;
  assign cnt_nxt      = cnt + 32'd1;
  assign max_hit      = (MAX_DESC != 0) && (cnt_nxt == 32'(MAX_DESC));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      rd_idx      <= 3'd0;
      rd_wait     <= 1'b0;
      stop_seen   <= 1'b0;
      w0          <= 32'd0;
      w2          <= 32'd0;
      w4          <= 32'd0;
      w6_len      <= 16'd0;
      w7_hi       <= 8'd0;
      cnt         <= 32'd0;
      busy        <= 1'b0;
      chain_done  <= 1'b0;
      chain_err   <= 1'b0;
      m_address   <= '0;
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_writedata <= 32'd0;
      desc_valid  <= 1'b0;
    end else begin
      chain_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (head_ptr[4:0] != 5'd0) begin
              chain_err  <= 1'b1;
              chain_done <= 1'b1;
            end else begin
              ptr       <= head_ptr;
              chain_err <= 1'b0;
              busy      <= 1'b1;
              cnt       <= 32'd0;
              stop_seen <= 1'b0;
              rd_idx    <= 3'd0;
              m_read    <= 1'b1;
              m_address <= head_ptr;
              state     <= S_RD;
            end
          end
        end
        S_RD: begin
          if (stop) stop_seen <= 1'b1;
          if (m_read && !m_waitrequest) begin
            m_read  <= 1'b0;
            rd_wait <= 1'b1;
          end
          if (rd_wait && m_readdatavalid) begin
            rd_wait <= 1'b0;
            case (rd_idx)
              3'd0:    w0     <= m_readdata;
              3'd2:    w2     <= m_readdata;
              3'd4:    w4     <= m_readdata;
              3'd6:    w6_len <= m_readdata[15:0];
              3'd7:    w7_hi  <= m_readdata[31:24];
              default: ;
            endcase
            // a stop seen at any point of the walk ends it once the in-flight read lands
            if (stop || stop_seen) begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              chain_done <= 1'b1;
            end else if (rd_idx == 3'd7) begin
              state <= S_CHECK;
            end else begin
              rd_idx    <= rd_idx + 3'd1;
              m_read    <= 1'b1;
              m_address <= ptr + ADDR_W'({rd_idx + 3'd1, 2'b00});
            end
          end
        end
        S_CHECK: begin
          if (!w7_hi[7]) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            chain_done <= 1'b1;
          end else begin
            desc_valid <= 1'b1;
            state      <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (desc_ready) begin
            desc_valid <= 1'b0;
            state      <= S_WAIT;
          end else if (stop) begin
            desc_valid <= 1'b0;
            state      <= S_IDLE;
            busy       <= 1'b0;
            chain_done <= 1'b1;
          end
        end
        S_WAIT: begin
          if (xfer_done) begin
            m_write     <= 1'b1;
            m_address   <= ptr + ADDR_W'(28);
            m_writedata <= {1'b0, w7_hi[6:0], xfer_status, xfer_bytes};
            state       <= S_WB;
          end
        end
        S_WB: begin
          if (!m_waitrequest) begin
            m_write <= 1'b0;
            cnt     <= cnt_nxt;
            if (w7_hi[6] || stop || max_hit || (w4[4:0] != 5'd0)) begin
              // a bad link only counts as an error when the chain would otherwise follow it
              if (!(w7_hi[6] || stop || max_hit)) chain_err <= 1'b1;
              state      <= S_IDLE;
              busy       <= 1'b0;
              chain_done <= 1'b1;
            end else begin
              ptr       <= ADDR_W'(w4);
              rd_idx    <= 3'd0;
              m_read    <= 1'b1;
              m_address <= ADDR_W'(w4);
              stop_seen <= 1'b0;
              state     <= S_RD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SGDMA_DESC_FETCHER_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        irq <= 1'b0;
    else if (chain_done) irq <= 1'b1;
    else if (irq_clear)  irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_sgdma_desc_fetcher.sv
// Bench for sgdma_desc_fetcher: descriptor RAM slave with programmable wait states, randomized datapath,
// and a descriptor-walk reference model over a private copy of the RAM.
module tb_sgdma_desc_fetcher;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] head_ptr = 32'd0;
  logic        stop = 1'b0;
  logic        busy, chain_done, chain_err;
  logic [31:0] m_address, m_writedata, m_readdata;
  logic        m_read, m_write, m_waitrequest, m_readdatavalid;
  logic [3:0]  m_byteenable;
  logic        desc_valid;
  logic        desc_ready = 1'b0;
  logic [31:0] desc_src, desc_dst;
  logic [15:0] desc_len;
  logic        xfer_done = 1'b0;
  logic [15:0] xfer_bytes = 16'd0;
  logic [7:0]  xfer_status = 8'd0;
`ifdef SGDMA_DESC_FETCHER_IRQ_EN
  logic        irq;
  logic        irq_clear = 1'b0;
`endif

  always #5 clk = ~clk;

  sgdma_desc_fetcher #(.ADDR_W(32), .MAX_DESC(0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .head_ptr(head_ptr), .stop(stop),
    .busy(busy), .chain_done(chain_done), .chain_err(chain_err),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src(desc_src), .desc_dst(desc_dst), .desc_len(desc_len),
    .xfer_done(xfer_done), .xfer_bytes(xfer_bytes),
`ifdef SGDMA_DESC_FETCHER_IRQ_EN
    .irq(irq), .irq_clear(irq_clear),
`endif
    .xfer_status(xfer_status)
  );

  // descriptor RAM slave: 64 words, 1-cycle read latency, ws wait cycles per access
  logic [31:0] mem [0:63];
  int          ws = 0;
  int          wcnt = 0;
  logic        rdv_r = 1'b0;
  logic [31:0] rdat_r = 32'd0;
  int          rd_cnt = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  assign m_waitrequest   = (m_read | m_write) && (wcnt < ws);
  assign m_readdatavalid = rdv_r;
  assign m_readdata      = rdat_r;

  always @(posedge clk) begin
    rdv_r <= 1'b0;
    if ((m_read | m_write) && !m_waitrequest) begin
      wcnt <= 0;
      if (m_read) begin
        rdv_r  <= 1'b1;
        rdat_r <= mem[m_address[7:2]];
        rd_cnt <= rd_cnt + 1;
      end else begin
        wa_q.push_back(m_address);
        wd_q.push_back(m_writedata);
      end
    end else if (m_read | m_write) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  int          vectors = 0;
  int          miscompares = 0;
  logic [79:0] off_q[$];
  logic [79:0] e_off[$];
  logic [31:0] e_wa[$];
  logic [31:0] e_wd[$];
  logic        e_err;
  int          e_rd;
  logic [31:0] mm [0:63];
  logic [15:0] xb [0:63];
  logic [7:0]  xs [0:63];
  int          done_cnt, rd_base, wr_base;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
  endtask

  task automatic set_desc(input logic [31:0] base, input logic [31:0] src, input logic [31:0] dst,
                          input logic [15:0] len, input logic [31:0] nxt, input logic [31:0] w7);
    int b;
    b = int'(base[7:2]);
    mem[b]     = src;
    mem[b + 2] = dst;
    mem[b + 4] = nxt;
    mem[b + 6] = {16'hA5A5, len};
    mem[b + 7] = w7;
  endtask

  // Reference: follow the linked list through a copy of RAM, applying each completion write.
  task automatic model(input logic [31:0] head);
    logic [31:0] p, wd;
    logic [31:0] w [0:7];
    int k, b;
    e_off.delete(); e_wa.delete(); e_wd.delete();
    e_err = 1'b0;
    e_rd  = 0;
    for (int i = 0; i < 64; i++) mm[i] = mem[i];
    if (head[4:0] != 5'd0) begin
      e_err = 1'b1;
      return;
    end
    p = head;
    k = 0;
    while (k < 64) begin
      b = int'(p[7:2]);
      for (int j = 0; j < 8; j++) w[j] = mm[(b + j) % 64];
      e_rd += 8;
      if (!w[7][31]) break;
      e_off.push_back({w[0], w[2], w[6][15:0]});
      wd = {1'b0, w[7][30:24], xs[k], xb[k]};
      e_wa.push_back(p + 32'd28);
      e_wd.push_back(wd);
      mm[(b + 7) % 64] = wd;
      k++;
      if (w[7][30]) break;
      if (w[4][4:0] != 5'd0) begin
        e_err = 1'b1;
        break;
      end
      p = w[4];
    end
  endtask

  // stop_mode: 0 none, 1 raise stop at the first read, 2 raise stop when the first offer appears
  task automatic run_chain(input logic [31:0] head, input int stop_mode, input bit inj, input bit spur);
    int   wapp, k, xc, post, cyc;
    bit   await_x, seen_done, injd, armed, prev_req, prev_wait, prev_rd, prev_wr;
    logic [31:0] prev_addr, prev_wd, ta;
    off_q.delete();
    done_cnt = 0;
    rd_base = rd_cnt;
    wr_base = wa_q.size();
    wapp = wr_base;
    k = 0; xc = 0; post = 0; cyc = 0;
    await_x = 0; seen_done = 0; injd = 0; armed = 0; prev_req = 0; prev_wait = 0;
    prev_rd = 0; prev_wr = 0; prev_addr = 0; prev_wd = 0;
    @(negedge clk);
    start = 1'b1;
    head_ptr = head;
    @(negedge clk);
    start = 1'b0;
    head_ptr = $urandom;
    chk("start_resp", {busy, chain_done}, (head[4:0] == 5'd0) ? 2'b10 : 2'b01);
    while (post < 4 && cyc < 4000) begin
      cyc++;
      if (prev_req && prev_wait)
        chk("req_hold", {m_read, m_write, m_address, m_writedata}, {prev_rd, prev_wr, prev_addr, prev_wd});
      if (m_readdatavalid) chk("one_outstanding", m_read, 1'b0);
      if (m_read | m_write) chk("addr_be", {m_address[1:0], m_byteenable}, 6'h0F);
      prev_req = m_read | m_write; prev_wait = m_waitrequest;
      prev_rd = m_read; prev_wr = m_write; prev_addr = m_address; prev_wd = m_writedata;
      while (wapp < wa_q.size()) begin
        ta = wa_q[wapp];
        mem[ta[7:2]] = wd_q[wapp];
        wapp++;
      end
      if (armed) begin
        chk("withdraw", {desc_valid, chain_done, busy}, 3'b010);
        armed = 0;
      end
      if (chain_done) begin
        done_cnt++;
        seen_done = 1;
      end
      if (seen_done) post++;
      if (seen_done) stop = 1'b0;
      else if (stop_mode == 1 && m_read) stop = 1'b1;
      start = 1'b0;
      if (inj && !injd && busy) begin
        start = 1'b1;
        head_ptr = 32'($urandom_range(0, 7)) << 5;
        injd = 1;
      end
      xfer_done = 1'b0;
      if (await_x) begin
        if (xc == 0) begin
          xfer_done = 1'b1;
          xfer_bytes = xb[k];
          xfer_status = xs[k];
          k++;
          await_x = 0;
        end else begin
          xc--;
        end
      end else if (spur && $urandom_range(0, 7) == 0) begin
        xfer_done = 1'b1;
        xfer_bytes = 16'($urandom);
        xfer_status = 8'($urandom);
      end
      desc_ready = 1'b0;
      if (desc_valid && stop_mode == 2 && !stop && !seen_done) begin
        stop = 1'b1;
        armed = 1;
      end else if (desc_valid && !stop && $urandom_range(0, 1) == 1) begin
        desc_ready = 1'b1;
        off_q.push_back({desc_src, desc_dst, desc_len});
        await_x = 1;
        xc = $urandom_range(0, 3);
      end else if (!desc_valid) begin
        desc_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    chk("chain_finished", seen_done, 1'b1);
    start = 1'b0; stop = 1'b0; xfer_done = 1'b0; desc_ready = 1'b0;
  endtask

  task automatic check_run(input string tag);
    int n;
    chk({tag, "_ndone"}, done_cnt, 1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, chain_err, e_err);
    chk({tag, "_reads"}, rd_cnt - rd_base, e_rd);
    chk({tag, "_noffers"}, off_q.size(), e_off.size());
    n = (off_q.size() < e_off.size()) ? off_q.size() : e_off.size();
    for (int i = 0; i < n; i++) chk({tag, "_offer"}, off_q[i], e_off[i]);
    chk({tag, "_nwrites"}, wa_q.size() - wr_base, e_wa.size());
    n = wa_q.size() - wr_base;
    if (e_wa.size() < n) n = e_wa.size();
    for (int i = 0; i < n; i++) chk({tag, "_write"}, {wa_q[wr_base + i], wd_q[wr_base + i]}, {e_wa[i], e_wd[i]});
  endtask

`ifdef SGDMA_DESC_FETCHER_IRQ_EN
  task automatic irq_clr_chk(input string tag);
    @(negedge clk);
    irq_clear = 1'b1;
    @(negedge clk);
    irq_clear = 1'b0;
    chk(tag, irq, 1'b0);
  endtask
`endif

  initial begin
    logic [31:0] h, nx, w7, t;
    logic [79:0] o;
    clear_mem();
    for (int i = 0; i < 64; i++) begin
      xb[i] = 16'($urandom);
      xs[i] = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    chk("reset_outs", {busy, chain_done, chain_err, m_read, m_write, desc_valid, m_address, m_writedata},
        70'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset", {busy, chain_done, chain_err, m_read, m_write, desc_valid, m_byteenable}, 10'h00F);
`ifdef SGDMA_DESC_FETCHER_IRQ_EN
    chk("irq_reset", irq, 1'b0);
`endif

    // single descriptor at 0x40
    clear_mem();
    set_desc(32'h40, 32'h1111_0000, 32'h2222_0000, 16'h0100, 32'h0, 32'h8000_0000);
    xb[0] = 16'h0100; xs[0] = 8'h00; ws = 0;
    model(32'h40);
    run_chain(32'h40, 0, 0, 0);
    check_run("single");
    o = (off_q.size() > 0) ? off_q[0] : 80'd0;
    chk("single_len", o[15:0], 16'h0100);
    t = (wa_q.size() > wr_base) ? wd_q[wr_base] : 32'hFFFF_FFFF;
    chk("single_wdata", t, 32'h0000_0100);
    t = (wa_q.size() > wr_base) ? wa_q[wr_base] : 32'hFFFF_FFFF;
    chk("single_waddr", t, 32'h0000_005C);

    // three-descriptor chain, zero then three wait states
    for (int pass = 0; pass < 2; pass++) begin
      clear_mem();
      set_desc(32'h00, 32'hA000_0000, 32'hB000_0000, 16'h0010, 32'h20, 32'h8000_0000);
      set_desc(32'h20, 32'hA000_1000, 32'hB000_1000, 16'h0020, 32'h40, 32'h8012_3456);
      set_desc(32'h40, 32'hA000_2000, 32'hB000_2000, 16'h0030, 32'h00, 32'hC000_0000);
      ws = (pass == 0) ? 0 : 3;
      model(32'h00);
      run_chain(32'h00, 0, 0, 0);
      check_run(pass == 0 ? "chain3" : "chain3_ws");
      for (int i = 0; i < 3; i++) begin
        t = (wa_q.size() > wr_base + i) ? wa_q[wr_base + i] : 32'hFFFF_FFFF;
        chk("chain3_waddr", t, 32'h1C + 32'(i) * 32'h20);
      end
    end

    // misaligned head: no bus activity, error flagged
    ws = 0;
    model(32'h44);
    run_chain(32'h44, 0, 0, 0);
    check_run("bad_head");
    chk("bad_head_err", chain_err, 1'b1);

    // head not owned by hardware; also clears the sticky error
    clear_mem();
    set_desc(32'h60, 32'h1, 32'h2, 16'h3, 32'h80, 32'h4000_0000);
    model(32'h60);
    run_chain(32'h60, 0, 0, 0);
    check_run("not_owned");

`ifdef SGDMA_DESC_FETCHER_IRQ_EN
    irq_clr_chk("irq_clear_pre");
`endif
    // stop while an offer is pending
    clear_mem();
    set_desc(32'h20, 32'h5, 32'h6, 16'h7, 32'h40, 32'h8000_0000);
    ws = 1;
    run_chain(32'h20, 2, 0, 0);
    chk("stop_offer_done", done_cnt, 1);
    chk("stop_offer_noffer", off_q.size(), 0);
    chk("stop_offer_nwrite", wa_q.size() - wr_base, 0);
    chk("stop_offer_reads", rd_cnt - rd_base, 8);
`ifdef SGDMA_DESC_FETCHER_IRQ_EN
    chk("irq_set", irq, 1'b1);
    irq_clr_chk("irq_cleared");
`endif

    // stop during the descriptor read
    ws = 0;
    run_chain(32'h20, 1, 0, 0);
    chk("stop_rd_done", done_cnt, 1);
    chk("stop_rd_reads", rd_cnt - rd_base, 1);
    chk("stop_rd_noffer", off_q.size(), 0);
    chk("stop_rd_nwrite", wa_q.size() - wr_base, 0);

    // self loop: second visit sees ownership cleared by the write-back
    clear_mem();
    set_desc(32'h60, 32'h77, 32'h88, 16'h99, 32'h60, 32'h8000_0000);
    model(32'h60);
    run_chain(32'h60, 0, 0, 1);
    check_run("self_loop");

    // misaligned next pointer after a completed descriptor
    clear_mem();
    set_desc(32'h20, 32'h1, 32'h2, 16'h3, 32'h84, 32'h8000_0000);
    ws = 2;
    model(32'h20);
    run_chain(32'h20, 0, 0, 0);
    check_run("bad_next");

    // randomized chains
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      for (int i = 0; i < 64; i++) begin
        xb[i] = 16'($urandom);
        xs[i] = 8'($urandom);
      end
      for (int s = 0; s < 8; s++) begin
        w7 = mem[s * 8 + 7];
        w7[31] = ($urandom_range(0, 9) != 0);
        w7[30] = ($urandom_range(0, 3) == 0);
        nx = 32'($urandom_range(0, 7)) << 5;
        if (!w7[30] && $urandom_range(0, 11) == 0) nx[4:0] = 5'($urandom_range(1, 31));
        mem[s * 8 + 4] = nx;
        mem[s * 8 + 7] = w7;
      end
      h = 32'($urandom_range(0, 7)) << 5;
      if ($urandom_range(0, 9) == 0) h[4:0] = 5'($urandom_range(1, 31));
      ws = $urandom_range(0, 2);
      model(h);
      run_chain(h, 0, (r % 3) == 0, (r % 2) == 0);
      check_run("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
